// File: rtl/lynx_kbd_pkg.sv
// rtl/lynx_kbd_pkg.sv - shared types, scan-code constants and PS/2-to-Lynx key map
package lynx_kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // One Lynx matrix position; valid=0 means "no key here"
    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } key_loc_t;

    // A PC key can drive up to two Lynx keys (e.g. cursor keys = SHIFT + key)
    typedef struct packed {
        key_loc_t a;
        key_loc_t b;
    } map_ent_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic key_loc_t loc(input logic [3:0] r, input logic [2:0] c);
        key_loc_t k;
        k.valid = 1'b1;
        k.row   = r;
        k.col   = c;
        return k;
    endfunction

    // Index is {extended, scan code}; anything not listed (incl. AA/FA/FE) is a miss
    function automatic map_ent_t KEY_MAP(input logic [8:0] code);
        map_ent_t e;
        e = '0;
        case (code)
            9'h012, 9'h059: e.a = loc(4'd0, 3'd0);
            9'h01C:         e.a = loc(4'd1, 3'd2);
            9'h029:         e.a = loc(4'd9, 3'd3);
            9'h05A:         e.a = loc(4'd8, 3'd3);
            9'h175: begin
                e.a = loc(4'd0, 3'd0);
                e.b = loc(4'd9, 3'd2);
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchroniser, 11-bit frame receiver and timeout
module ps2_rx_frame
    import lynx_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            clk_prev_q, fall_q;
    rx_state_t       state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] tocnt_q, tocnt_d;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Registered 1->0 detect on the synchronised PS/2 clock
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_prev_q <= clk_s2_q;
            fall_q     <= clk_prev_q & ~clk_s2_q;
        end
    end

    // Frame state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tocnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tocnt_q  <= tocnt_d;
        end
    end

    // Next state: bits only move on falling edges; otherwise the timeout runs
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tocnt_d      = tocnt_q;
        byte_valid_o = 1'b0;
        err_o        = 1'b0;
        if (fall_q) begin
            tocnt_d = '0;
            case (state_q)
                RX_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = RX_DATA;
                        bitcnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if ((^{shift_q, par_q}) && dat_s2_q) begin
                        byte_valid_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q == RX_IDLE) begin
            tocnt_d = '0;
        end else if (tocnt_q == TO_LAST) begin
            state_d  = RX_IDLE;
            bitcnt_d = '0;
            tocnt_d  = '0;
            err_o    = 1'b1;
        end else begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/lynx_ps2_keymatrix.sv
// rtl/lynx_ps2_keymatrix.sv - PS/2 scan-code decoder driving the Lynx 10x8 key matrix
module lynx_ps2_keymatrix
    import lynx_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter int ROWS        = 10
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] ps2_i,
    input  logic [3:0] row_sel_i,
    output logic [7:0] col_n_o,
    output logic       key_strobe_o,
    output logic       frame_err_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic       brk_f_q, ext_f_q;
    logic       hit_q, brk_q;
    map_ent_t   ent_q;
    map_ent_t   lookup;
    logic [7:0] matrix_q [ROWS];
    logic       strobe_q;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (clock_i),
        .rst_i        (reset_i),
        .ps2_clk_i    (ps2_i[0]),
        .ps2_dat_i    (ps2_i[1]),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .err_o        (rx_err)
    );

    assign lookup = KEY_MAP({ext_f_q, rx_byte});

    // Prefix flags and registered table lookup (first decode cycle)
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            brk_f_q <= 1'b0;
            ext_f_q <= 1'b0;
            hit_q   <= 1'b0;
            brk_q   <= 1'b0;
            ent_q   <= '0;
        end else begin
            hit_q <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk_f_q <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_f_q <= 1'b1;
                end else begin
                    ent_q   <= lookup;
                    hit_q   <= lookup.a.valid;
                    brk_q   <= brk_f_q;
                    brk_f_q <= 1'b0;
                    ext_f_q <= 1'b0;
                end
            end
        end
    end

    // Matrix write (second decode cycle); make clears the bit, break sets it
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int r = 0; r < ROWS; r++) begin
                matrix_q[r] <= 8'hFF;
            end
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= hit_q;
            if (hit_q) begin
                matrix_q[ent_q.a.row][ent_q.a.col] <= brk_q;
                if (ent_q.b.valid) begin
                    matrix_q[ent_q.b.row][ent_q.b.col] <= brk_q;
                end
            end
        end
    end

    assign col_n_o      = (int'(row_sel_i) < ROWS) ? matrix_q[row_sel_i] : 8'hFF;
    assign key_strobe_o = strobe_q;
    assign frame_err_o  = rx_err;

endmodule

// File: tb/tb_lynx_ps2_keymatrix.sv
// tb/tb_lynx_ps2_keymatrix.sv - directed self-checking bench for lynx_ps2_keymatrix
module tb_lynx_ps2_keymatrix;

    localparam int T    = 20000;
    localparam int HALF = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ps2   = 2'b11;
    logic [3:0] row_sel = 4'd0;
    logic [7:0] col_n;
    logic       key_strobe;
    logic       frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobe_cnt   = 0;
    int err_cnt      = 0;

    lynx_ps2_keymatrix #(
        .TIMEOUT_CYC (T),
        .ROWS        (10)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .ps2_i        (ps2),
        .row_sel_i    (row_sel),
        .col_n_o      (col_n),
        .key_strobe_o (key_strobe),
        .frame_err_o  (frame_err)
    );

    always #5 clock = ~clock;

    // Pulse counters; sampled at the edge so they see the value of the cycle just ending
    always @(posedge clock) begin
        if (key_strobe) strobe_cnt++;
        if (frame_err)  err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exhausted, got running want finished");
        $fatal(1);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic d, input bit hold_low);
        @(negedge clock);
        ps2[1] = d;
        wait_neg(HALF);
        ps2[0] = 1'b0;
        if (!hold_low) begin
            wait_neg(HALF);
            ps2[0] = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit hold_last);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            drive_bit(f[i], hold_last && (i == nbits - 1));
        end
    endtask

    task automatic release_clk();
        wait_neg(HALF);
        ps2[0] = 1'b1;
        wait_neg(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
        wait_neg(4);
    endtask

    task automatic read_row(input logic [3:0] r, output logic [7:0] v);
        row_sel = r;
        #1;
        v = col_n;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        for (int r = 0; r < 10; r++) begin
            read_row(4'(r), v);
            tests_run++;
            if (v !== 8'hFF) begin tests_failed++; $display("FAIL reset_row%0d: got %h want ff", r, v); end
        end
        tests_run++;
        if (key_strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe: got %b want 0", key_strobe); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", frame_err); end
    endtask

    task automatic test_make();
        logic [7:0] v;
        int s0;
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b0, 11, 1'b1);
        wait_neg(4);
        read_row(4'd1, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL make_early_row1: got %h want ff", v); end
        tests_run++;
        if (key_strobe !== 1'b0) begin tests_failed++; $display("FAIL make_early_strobe: got %b want 0", key_strobe); end
        wait_neg(1);
        read_row(4'd1, v);
        tests_run++;
        if (v !== 8'hFB) begin tests_failed++; $display("FAIL make_row1: got %h want fb", v); end
        tests_run++;
        if (key_strobe !== 1'b1) begin tests_failed++; $display("FAIL make_strobe: got %b want 1", key_strobe); end
        wait_neg(1);
        tests_run++;
        if (key_strobe !== 1'b0) begin tests_failed++; $display("FAIL make_strobe_end: got %b want 0", key_strobe); end
        release_clk();
        tests_run++;
        if (strobe_cnt - s0 != 1) begin tests_failed++; $display("FAIL make_strobe_count: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_break();
        logic [7:0] v;
        int s0;
        s0 = strobe_cnt;
        send_byte(8'hF0);
        read_row(4'd1, v);
        tests_run++;
        if (v !== 8'hFB) begin tests_failed++; $display("FAIL break_prefix_row1: got %h want fb", v); end
        tests_run++;
        if (strobe_cnt != s0) begin tests_failed++; $display("FAIL break_prefix_strobe: got %0d want %0d", strobe_cnt, s0); end
        send_byte(8'h1C);
        read_row(4'd1, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL break_row1: got %h want ff", v); end
        tests_run++;
        if (strobe_cnt - s0 != 1) begin tests_failed++; $display("FAIL break_strobe_count: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_ext_multi();
        logic [7:0] v;
        int s0;
        s0 = strobe_cnt;
        send_byte(8'hE0);
        send_byte(8'h75);
        read_row(4'd9, v);
        tests_run++;
        if (v !== 8'hFB) begin tests_failed++; $display("FAIL ext_up_row9: got %h want fb", v); end
        read_row(4'd0, v);
        tests_run++;
        if (v !== 8'hFE) begin tests_failed++; $display("FAIL ext_up_row0: got %h want fe", v); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        read_row(4'd9, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL ext_rel_row9: got %h want ff", v); end
        read_row(4'd0, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL ext_rel_row0: got %h want ff", v); end
        tests_run++;
        if (strobe_cnt - s0 != 2) begin tests_failed++; $display("FAIL ext_strobe_count: got %0d want 2", strobe_cnt - s0); end
    endtask

    task automatic test_parity_err();
        logic [7:0] v;
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        wait_neg(4);
        tests_run++;
        if (err_cnt - e0 != 1) begin tests_failed++; $display("FAIL parity_err_count: got %0d want 1", err_cnt - e0); end
        read_row(4'd1, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL parity_row1: got %h want ff", v); end
        tests_run++;
        if (strobe_cnt != s0) begin tests_failed++; $display("FAIL parity_strobe: got %0d want %0d", strobe_cnt, s0); end
        send_byte(8'hAA);
        send_byte(8'h29);
        read_row(4'd9, v);
        tests_run++;
        if (v !== 8'hF7) begin tests_failed++; $display("FAIL after_err_row9: got %h want f7", v); end
        tests_run++;
        if (strobe_cnt - s0 != 1) begin tests_failed++; $display("FAIL after_err_strobe: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        int e0;
        e0 = err_cnt;
        send_frame(8'h00, 1'b0, 4, 1'b1);
        wait_neg(HALF);
        ps2[0] = 1'b1;
        // 3 cycles of sync/edge-detect, then the counter expires T-1 cycles after the edge
        wait_neg(T + 2 - HALF);
        tests_run++;
        if (frame_err !== 1'b0 || err_cnt != e0) begin
            tests_failed++;
            $display("FAIL timeout_early: got err=%b count=%0d want 0 and %0d", frame_err, err_cnt, e0);
        end
        wait_neg(1);
        tests_run++;
        if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_pulse: got %b want 1", frame_err); end
        wait_neg(1);
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_pulse_end: got %b want 0", frame_err); end
        tests_run++;
        if (err_cnt - e0 != 1) begin tests_failed++; $display("FAIL timeout_count: got %0d want 1", err_cnt - e0); end
        send_byte(8'h5A);
        read_row(4'd8, v);
        tests_run++;
        if (v !== 8'hF7) begin tests_failed++; $display("FAIL timeout_next_row8: got %h want f7", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int s0;
        send_byte(8'h12);
        read_row(4'd0, v);
        tests_run++;
        if (v !== 8'hFE) begin tests_failed++; $display("FAIL shift_row0: got %h want fe", v); end
        send_frame(8'h1C, 1'b0, 3, 1'b0);
        s0 = strobe_cnt;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int r = 0; r < 10; r++) begin
            read_row(4'(r), v);
            tests_run++;
            if (v !== 8'hFF) begin tests_failed++; $display("FAIL midreset_row%0d: got %h want ff", r, v); end
        end
        read_row(4'd12, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL midreset_row12: got %h want ff", v); end
        tests_run++;
        if (strobe_cnt != s0 || key_strobe !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_strobe: got count=%0d strobe=%b want %0d and 0", strobe_cnt, key_strobe, s0);
        end
        send_byte(8'h1C);
        read_row(4'd1, v);
        tests_run++;
        if (v !== 8'hFB) begin tests_failed++; $display("FAIL midreset_next_row1: got %h want fb", v); end
        read_row(4'd0, v);
        tests_run++;
        if (v !== 8'hFF) begin tests_failed++; $display("FAIL midreset_next_row0: got %h want ff", v); end
    endtask

    initial begin
        wait_neg(3);
        reset = 1'b0;
        wait_neg(2);
        test_reset();
        test_make();
        test_break();
        test_ext_multi();
        test_parity_err();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
